// File: rtl/neurram_spike_accumulator.sv
// Per-neuron saturating spike counters fed by the SPI readout bus.
// Captures on each rising edge of spi_idle while armed, and on host command
// streams every counter out as packed 32-bit words over valid/ready.
module neurram_spike_accumulator #(
  parameter int unsigned N_NEURONS     = 576,
  parameter int unsigned CNT_WIDTH     = 8,    // 4, 8 or 16
  parameter bit          CLEAR_ON_READ = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_acc_enable,
  input  logic                 i_spi_idle,
  input  logic [N_NEURONS-1:0] i_spi_from_neurram,
  input  logic                 i_clear,
  input  logic                 i_readout_start,
  output logic [31:0]          o_out_data,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic                 o_out_last,
  output logic                 o_busy,
  output logic [15:0]          o_sample_count,
  output logic                 o_missed_capture
);

  localparam int unsigned P  = 32 / CNT_WIDTH;
  localparam int unsigned NW = N_NEURONS / P;
  localparam int unsigned KW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic {StIdle, StReadout} state_e;

  state_e                          r_state, w_state_next;
  logic [KW-1:0]                   r_k, w_k_next;
  // Counter i lives at bits [i*CNT_WIDTH +: CNT_WIDTH], so word k is simply
  // the 32-bit slice starting at bit 32*k.
  logic [N_NEURONS*CNT_WIDTH-1:0]  r_cnt, w_cnt_next;
  logic                            r_idle_d;
  logic [15:0]                     r_sample_count;
  logic                            r_missed;

  logic w_cap, w_accept, w_final;

  assign w_cap    = i_acc_enable & i_spi_idle & ~r_idle_d;
  assign w_accept = (r_state == StReadout) & i_out_ready;
  assign w_final  = (r_k == KW'(NW - 1));

  // State and word-index register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_k     <= '0;
    end else begin
      r_state <= w_state_next;
      r_k     <= w_k_next;
    end
  end

  // Next-state logic and streaming outputs; data is zero outside READOUT.
  always_comb begin
    w_state_next = r_state;
    w_k_next     = r_k;
    o_busy       = 1'b0;
    o_out_valid  = 1'b0;
    o_out_last   = 1'b0;
    o_out_data   = '0;
    unique case (r_state)
      StIdle: begin
        if (i_readout_start) begin
          w_state_next = StReadout;
          w_k_next     = '0;
        end
      end
      StReadout: begin
        o_busy      = 1'b1;
        o_out_valid = 1'b1;
        o_out_last  = w_final;
        o_out_data  = r_cnt[{r_k, 5'd0} +: 32];
        if (w_accept) begin
          if (w_final) begin
            w_state_next = StIdle;
            w_k_next     = '0;
          end else begin
            w_k_next = r_k + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Counter next-state: clear beats capture in IDLE; clear-on-read in READOUT.
  always_comb begin
    logic [CNT_WIDTH:0] v_sum;
    v_sum      = '0;
    w_cnt_next = r_cnt;
    if (r_state == StIdle) begin
      if (i_clear) begin
        w_cnt_next = '0;
      end else if (w_cap) begin
        for (int unsigned i = 0; i < N_NEURONS; i++) begin
          // One extra bit catches the carry so the counter clamps, never wraps.
          v_sum = {1'b0, r_cnt[i*CNT_WIDTH +: CNT_WIDTH]} +
                  {{CNT_WIDTH{1'b0}}, i_spi_from_neurram[i]};
          w_cnt_next[i*CNT_WIDTH +: CNT_WIDTH] = v_sum[CNT_WIDTH] ? '1 : v_sum[CNT_WIDTH-1:0];
        end
      end
    end else if (CLEAR_ON_READ && w_accept) begin
      w_cnt_next[{r_k, 5'd0} +: 32] = '0;
    end
  end

  // Counter storage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  // Edge detector, sample counter and sticky missed-capture flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idle_d       <= 1'b1;
      r_sample_count <= '0;
      r_missed       <= 1'b0;
    end else begin
      r_idle_d <= i_spi_idle;
      if (r_state == StIdle) begin
        if (i_clear) begin
          r_sample_count <= '0;
          r_missed       <= 1'b0;
        end else if (w_cap && (r_sample_count != 16'hFFFF)) begin
          r_sample_count <= r_sample_count + 16'd1;
        end
      end else begin
        if (w_cap) begin
          r_missed <= 1'b1;
        end
        if (CLEAR_ON_READ && w_accept && w_final) begin
          r_sample_count <= '0;
        end
      end
    end
  end

  assign o_sample_count   = r_sample_count;
  assign o_missed_capture = r_missed;

endmodule

// File: tb/tb_neurram_spike_accumulator.sv
// Scoreboard bench for neurram_spike_accumulator (default parameters).
// Stimulus pushes expected words into a queue; a negedge monitor pops and
// compares each accepted word and checks hold-stability under backpressure.
module tb_neurram_spike_accumulator;

  localparam int N  = 576;
  localparam int NW = 144;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          acc_enable = 1'b0;
  logic          spi_idle = 1'b1;
  logic [N-1:0]  bus = '0;
  logic          clear = 1'b0;
  logic          readout_start = 1'b0;
  logic          out_ready = 1'b0;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          out_last;
  logic          busy;
  logic [15:0]   sample_count;
  logic          missed_capture;

  int            errors = 0;
  int            checks = 0;
  int            n_acc = 0;
  logic [32:0]   exp_q[$];
  int            model[N];

  neurram_spike_accumulator dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_acc_enable       (acc_enable),
    .i_spi_idle         (spi_idle),
    .i_spi_from_neurram (bus),
    .i_clear            (clear),
    .i_readout_start    (readout_start),
    .o_out_data         (out_data),
    .o_out_valid        (out_valid),
    .i_out_ready        (out_ready),
    .o_out_last         (out_last),
    .o_busy             (busy),
    .o_sample_count     (sample_count),
    .o_missed_capture   (missed_capture)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every accepted word; check stability while stalled.
  logic        hold = 1'b0;
  logic [32:0] held = '0;
  always @(negedge clk) begin
    logic [32:0] e;
    if (out_valid && hold) check("hold_stable", {out_last, out_data}, held);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none", out_data);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("word_%0d", n_acc), {out_last, out_data}, e);
      end
      n_acc++;
    end
    hold = out_valid && !out_ready;
    held = {out_last, out_data};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_zero();
    for (int i = 0; i < N; i++) model[i] = 0;
  endtask

  task automatic model_apply(input logic [N-1:0] b);
    for (int i = 0; i < N; i++) if (b[i] && model[i] < 255) model[i]++;
  endtask

  // One rising edge of spi_idle; the capture happens at the second edge.
  task automatic capture(input logic [N-1:0] b, input bit apply);
    bus = b;
    spi_idle = 1'b0;
    tick();
    spi_idle = 1'b1;
    if (apply && acc_enable) model_apply(b);
    tick();
  endtask

  // Queue the expected stream from the model, then clear-on-read the model.
  task automatic push_words();
    logic [31:0] w;
    for (int k = 0; k < NW; k++) begin
      for (int j = 0; j < 4; j++) w[j*8 +: 8] = 8'(model[k*4+j]);
      exp_q.push_back({(k == NW - 1), w});
    end
    model_zero();
  endtask

  task automatic start_readout();
    push_words();
    readout_start = 1'b1;
    tick();
    readout_start = 1'b0;
    check("valid_after_start", {32'd0, out_valid}, 33'd1);
  endtask

  task automatic drain(input bit toggle, input int base);
    for (int c = 0; c < 1000; c++) begin
      out_ready = toggle ? ~out_ready : 1'b1;
      tick();
      if (!busy) break;
    end
    out_ready = 1'b0;
    check("readout_done", {32'd0, busy}, 33'd0);
    check("words_accepted", 33'(n_acc - base), 33'(NW));
    check("queue_empty", 33'(exp_q.size()), 33'd0);
  endtask

  initial begin
    logic [N-1:0] b;
    int base;
    model_zero();

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_valid", {32'd0, out_valid}, 33'd0);
    check("rst_busy", {32'd0, busy}, 33'd0);
    check("rst_last", {32'd0, out_last}, 33'd0);
    check("rst_data", {1'b0, out_data}, 33'd0);
    check("rst_samples", {17'd0, sample_count}, 33'd0);
    check("rst_missed", {32'd0, missed_capture}, 33'd0);
    rst = 1'b0;
    tick();

    // Capture counting: bits 0 and 575, three captures
    acc_enable = 1'b1;
    b = '0;
    b[0] = 1'b1;
    b[N-1] = 1'b1;
    repeat (3) capture(b, 1'b1);
    check("samples_3", {17'd0, sample_count}, 33'd3);
    base = n_acc;
    start_readout();
    drain(1'b0, base);
    check("samples_cleared", {17'd0, sample_count}, 33'd0);

    // Saturation, then readout under toggling backpressure
    repeat (300) capture('1, 1'b1);
    check("samples_300", {17'd0, sample_count}, 33'd300);
    base = n_acc;
    start_readout();
    drain(1'b1, base);

    // Missed capture during READOUT
    b = '0;
    b[4] = 1'b1;
    b[5] = 1'b1;
    capture(b, 1'b1);
    base = n_acc;
    start_readout();
    out_ready = 1'b0;
    capture('1, 1'b0);
    check("missed_set", {32'd0, missed_capture}, 33'd1);
    check("samples_unchanged", {17'd0, sample_count}, 33'd1);
    drain(1'b0, base);
    check("missed_sticky", {32'd0, missed_capture}, 33'd1);
    capture(b, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_zero();
    check("missed_cleared", {32'd0, missed_capture}, 33'd0);
    check("samples_after_clear", {17'd0, sample_count}, 33'd0);

    // Gating: no capture while disarmed
    acc_enable = 1'b0;
    capture('1, 1'b1);
    check("gated_samples", {17'd0, sample_count}, 33'd0);
    base = n_acc;
    start_readout();
    drain(1'b0, base);

    // Clear coincident with a capture: clear wins
    acc_enable = 1'b1;
    capture(b, 1'b1);
    spi_idle = 1'b0;
    tick();
    spi_idle = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_zero();
    check("clear_wins_samples", {17'd0, sample_count}, 33'd0);

    // readout_start coincident with a capture: word 0 includes the sample
    b = '0;
    b[1] = 1'b1;
    b[300] = 1'b1;
    bus = b;
    spi_idle = 1'b0;
    tick();
    spi_idle = 1'b1;
    readout_start = 1'b1;
    model_apply(b);
    push_words();
    base = n_acc;
    tick();
    readout_start = 1'b0;
    check("valid_coincident", {32'd0, out_valid}, 33'd1);
    drain(1'b0, base);

    // Reset mid-readout at word 50
    capture('1, 1'b1);
    base = n_acc;
    start_readout();
    out_ready = 1'b1;
    for (int c = 0; c < 500; c++) begin
      if (n_acc - base >= 50) break;
      tick();
    end
    check("reached_word50", 33'(n_acc - base), 33'd50);
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    check("midrst_valid", {32'd0, out_valid}, 33'd0);
    check("midrst_busy", {32'd0, busy}, 33'd0);
    check("midrst_samples", {17'd0, sample_count}, 33'd0);
    rst = 1'b0;
    exp_q.delete();
    model_zero();
    tick();
    base = n_acc;
    start_readout();
    drain(1'b0, base);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
